// File: rtl/smips_pkg.sv
// Shared definitions for the multi-cycle smips controller: FSM states,
// instruction field encodings and ALU operation codes.
package smips_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM_READ,
    ST_MEM_WRITE,
    ST_WRITEBACK,
    ST_BRANCH,
    ST_HALT
  } state_e;

  // Opcode field, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Funct field for R-type, instruction[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation select
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field onto the ALU operation select and flags
// funct codes the datapath does not implement.
import smips_pkg::*;

module alu_decoder (
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  // Pure lookup; unknown funct reports invalid so the controller can halt
  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for smips. One state register; the
// next state and all datapath control lines are decoded combinationally
// from the state and the held opcode/funct. Only the FETCH and BRANCH
// strobes look at mem_ready/zero directly.
import smips_pkg::*;

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ifetch_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [2:0] alu_ctrl,
  output logic       alu_src,
  output logic       reg_dest,
  output logic       reg_write_enable,
  output logic       ram_read_enable,
  output logic       ram_write_enable,
  output logic       write_back_select,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [2:0] rtype_alu;
  logic       funct_valid;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_ctrl    (rtype_alu),
    .funct_valid (funct_valid)
  );

  // State register; reset returns to FETCH from anywhere, including HALT
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next-state: memory states stall on mem_ready, HALT is absorbing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:              state_d = funct_valid ? ST_EXECUTE : ST_HALT;
          OP_LW, OP_SW, OP_ADDI: state_d = ST_EXECUTE;
          OP_BEQ:                state_d = ST_BRANCH;
          default:               state_d = ST_HALT;
        endcase
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: state_d = ST_WRITEBACK;
          OP_LW:             state_d = ST_MEM_READ;
          OP_SW:             state_d = ST_MEM_WRITE;
          default:           state_d = ST_HALT;
        endcase
      end
      ST_MEM_READ:  if (mem_ready) state_d = ST_WRITEBACK;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held so a
  // stalled memory access is abandoned without a stray write
  always_comb begin
    ifetch_req        = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_src            = 1'b0;
    alu_ctrl          = ALU_AND;
    alu_src           = 1'b0;
    reg_dest          = 1'b0;
    reg_write_enable  = 1'b0;
    ram_read_enable   = 1'b0;
    ram_write_enable  = 1'b0;
    write_back_select = 1'b0;
    halted            = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          ifetch_req = 1'b1;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        ST_EXECUTE: begin
          if (opcode == OP_RTYPE) begin
            alu_ctrl = rtype_alu;
          end else begin
            alu_ctrl = ALU_ADD;
            alu_src  = 1'b1;
          end
        end
        ST_MEM_READ: begin
          alu_ctrl        = ALU_ADD;
          alu_src         = 1'b1;
          ram_read_enable = 1'b1;
        end
        ST_MEM_WRITE: begin
          alu_ctrl         = ALU_ADD;
          alu_src          = 1'b1;
          ram_write_enable = 1'b1;
        end
        ST_WRITEBACK: begin
          reg_write_enable = 1'b1;
          if (opcode == OP_RTYPE) begin
            reg_dest = 1'b1;
          end else if (opcode == OP_LW) begin
            write_back_select = 1'b1;
            alu_ctrl          = ALU_ADD;
            alu_src           = 1'b1;
          end
        end
        ST_BRANCH: begin
          alu_ctrl = ALU_SUB;
          pc_src   = 1'b1;
          pc_write = zero;
        end
        ST_HALT:  halted = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each scenario queues per-cycle
// stimulus alongside the control vector expected in that cycle, then plays
// the queue out and compares the DUT outputs cycle by cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       ifetch_req, ir_write, pc_write, pc_src;
  logic [2:0] alu_ctrl;
  logic       alu_src, reg_dest, reg_write_enable;
  logic       ram_read_enable, ram_write_enable, write_back_select, halted;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .ifetch_req(ifetch_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .reg_dest(reg_dest), .reg_write_enable(reg_write_enable),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .write_back_select(write_back_select), .halted(halted)
  );

  // {ifetch,irw,pcw,pcsrc,alu[2:0],asrc,rdest,rwe,rre,ramwe,wbs,halted}
  logic [13:0] outs;
  assign outs = {ifetch_req, ir_write, pc_write, pc_src, alu_ctrl, alu_src,
                 reg_dest, reg_write_enable, ram_read_enable,
                 ram_write_enable, write_back_select, halted};

  typedef struct packed { logic rst; logic mr; logic z; } stim_t;
  stim_t       stim_q[$];
  logic [13:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [13:0] ev(input logic ifr, irw, pcw, pcs,
                                     input logic [2:0] alu,
                                     input logic asrc, rdst, rwe, rre, rwr,
                                     wbs, h);
    return {ifr, irw, pcw, pcs, alu, asrc, rdst, rwe, rre, rwr, wbs, h};
  endfunction

  // Expected control vectors written out from the state descriptions
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_SUB = 3'b110, A_SLT = 3'b111;
  logic [13:0] E_ZERO, E_FWAIT, E_FGO, E_DEC, E_EXI, E_MRD, E_MWR;
  logic [13:0] E_WBR, E_WBADDI, E_WBLW, E_HALT;
  initial begin
    E_ZERO   = ev(0,0,0,0,A_AND,0,0,0,0,0,0,0);
    E_FWAIT  = ev(1,0,0,0,A_AND,0,0,0,0,0,0,0);
    E_FGO    = ev(1,1,1,0,A_AND,0,0,0,0,0,0,0);
    E_DEC    = ev(0,0,0,0,A_AND,0,0,0,0,0,0,0);
    E_EXI    = ev(0,0,0,0,A_ADD,1,0,0,0,0,0,0);
    E_MRD    = ev(0,0,0,0,A_ADD,1,0,0,1,0,0,0);
    E_MWR    = ev(0,0,0,0,A_ADD,1,0,0,0,1,0,0);
    E_WBR    = ev(0,0,0,0,A_AND,0,1,1,0,0,0,0);
    E_WBADDI = ev(0,0,0,0,A_AND,0,0,1,0,0,0,0);
    E_WBLW   = ev(0,0,0,0,A_ADD,1,0,1,0,0,1,0);
    E_HALT   = ev(0,0,0,0,A_AND,0,0,0,0,0,0,1);
  end

  task automatic push(input logic r, input logic m, input logic z,
                      input logic [13:0] e);
    stim_t s;
    s.rst = r; s.mr = m; s.z = z;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s; logic [13:0] e;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
    opcode = 6'b000000; funct = 6'b100000;
    for (int i = 0; i < 3; i++) push(1, 1, 1, E_ZERO);
    push(0, 0, 0, E_FWAIT);   // first cycle out of reset is FETCH
    push(0, 1, 0, E_FGO);     // instruction accepted
    push(0, 0, 0, E_DEC);     // add decodes
    push(0, 0, 0, ev(0,0,0,0,A_ADD,0,0,0,0,0,0,0));
    push(0, 0, 0, E_WBR);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; mem_ready = s.mr; zero = s.z;
      @(negedge clk);
      n_checks++;
      if (outs !== e) $display("FAIL reset_add got=%b want=%b", outs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    stim_t s; logic [13:0] e;
    logic [5:0] fn[4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] al[4] = '{A_SUB, A_AND, A_OR, A_SLT};
    for (int k = 0; k < 4; k++) begin
      opcode = 6'b000000; funct = fn[k];
      push(0, 1, 0, E_FGO);
      push(0, 1, 0, E_DEC);
      push(0, 1, 0, ev(0,0,0,0,al[k],0,0,0,0,0,0,0));
      push(0, 1, 0, E_WBR);
      while (stim_q.size() > 0) begin
        s = stim_q.pop_front(); e = exp_q.pop_front();
        reset = s.rst; mem_ready = s.mr; zero = s.z;
        @(negedge clk);
        n_checks++;
        if (outs !== e) $display("FAIL rtype_f%b got=%b want=%b", funct, outs, e);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_addi();
    stim_t s; logic [13:0] e;
    opcode = 6'b001000; funct = 6'b101010;
    push(0, 0, 0, E_FWAIT);   // one fetch stall
    push(0, 1, 0, E_FGO);
    push(0, 1, 0, E_DEC);
    push(0, 1, 0, E_EXI);
    push(0, 1, 0, E_WBADDI);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; mem_ready = s.mr; zero = s.z;
      @(negedge clk);
      n_checks++;
      if (outs !== e) $display("FAIL addi got=%b want=%b", outs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    stim_t s; logic [13:0] e;
    opcode = 6'b100011; funct = 6'b000000;
    push(0, 1, 0, E_FGO);
    push(0, 1, 0, E_DEC);
    push(0, 1, 0, E_EXI);
    push(0, 0, 0, E_MRD);
    push(0, 0, 0, E_MRD);
    push(0, 1, 0, E_MRD);
    push(0, 1, 0, E_WBLW);
    push(0, 0, 0, E_FWAIT);   // back in FETCH after 7 cycles
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; mem_ready = s.mr; zero = s.z;
      @(negedge clk);
      n_checks++;
      if (outs !== e) $display("FAIL lw_stall got=%b want=%b", outs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    stim_t s; logic [13:0] e;
    opcode = 6'b000100; funct = 6'b100000;
    for (int k = 1; k >= 0; k--) begin
      push(0, 1, k[0], E_FGO);
      push(0, 1, k[0], E_DEC);
      push(0, 1, k[0], ev(0,0,k[0],1,A_SUB,0,0,0,0,0,0,0));
    end
    push(0, 0, 1, E_FWAIT);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; mem_ready = s.mr; zero = s.z;
      @(negedge clk);
      n_checks++;
      if (outs !== e) $display("FAIL beq_z%b got=%b want=%b", zero, outs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    stim_t s; logic [13:0] e;
    opcode = 6'b101011; funct = 6'b100000;
    push(0, 1, 0, E_FGO);
    push(0, 1, 0, E_DEC);
    push(0, 1, 0, E_EXI);
    push(0, 1, 0, E_MWR);
    push(0, 1, 0, E_FGO);     // next sw, with a write stall
    push(0, 0, 0, E_DEC);
    push(0, 0, 0, E_EXI);
    push(0, 0, 0, E_MWR);
    push(0, 1, 0, E_MWR);
    push(0, 0, 0, E_FWAIT);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; mem_ready = s.mr; zero = s.z;
      @(negedge clk);
      n_checks++;
      if (outs !== e) $display("FAIL sw got=%b want=%b", outs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    stim_t s; logic [13:0] e;
    logic [5:0] op[2] = '{6'b111111, 6'b000000};
    logic [5:0] fn[2] = '{6'b100000, 6'b000000};
    for (int k = 0; k < 2; k++) begin
      opcode = op[k]; funct = fn[k];
      push(0, 1, 0, E_FGO);
      push(0, 1, 0, E_DEC);
      for (int i = 0; i < 11; i++) push(0, i[0], ~i[0], E_HALT);
      push(1, 1, 0, E_ZERO);  // reset clears halted immediately
      push(0, 0, 0, E_FWAIT);
      while (stim_q.size() > 0) begin
        s = stim_q.pop_front(); e = exp_q.pop_front();
        reset = s.rst; mem_ready = s.mr; zero = s.z;
        @(negedge clk);
        n_checks++;
        if (outs !== e) $display("FAIL halt_op%b got=%b want=%b", opcode, outs, e);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    stim_t s; logic [13:0] e;
    opcode = 6'b101011; funct = 6'b000000;
    push(0, 1, 0, E_FGO);
    push(0, 1, 0, E_DEC);
    push(0, 0, 0, E_EXI);
    push(0, 0, 0, E_MWR);
    push(1, 0, 0, E_ZERO);    // reset mid-stall drops the write
    push(0, 0, 0, E_FWAIT);
    push(0, 1, 0, E_FGO);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; mem_ready = s.mr; zero = s.z;
      @(negedge clk);
      n_checks++;
      if (outs !== e) $display("FAIL reset_mid_write got=%b want=%b", outs, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = 6'b0; funct = 6'b0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_addi();
    test_lw_stall();
    test_beq();
    test_sw();
    test_halt();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller that turns the smips datapath into a multi-cycle machine sharing a single ALU and a stallable memory port. Holds a Moore-style state machine plus a few mem_ready/zero-qualified strobes. Decodes the held instruction's opcode/funct and drives every datapath control line (ALU op, muxes, write enables) per state. Sits beside `program_sequencer`, `register_file`, `alu` and `data_memory` inside `smips`, replacing fixed single-cycle decode.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- opcode  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU result == 0, valid in BRANCH state
- mem_ready  in  1  memory completes current fetch/read/write this cycle
- ifetch_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = sign-extended branch target
- alu_ctrl  out  3  ALU op
- alu_src  out  1  0 = register data_2, 1 = sign-extended immediate
- reg_dest  out  1  0 = rt [20:16], 1 = rd [15:11]
- reg_write_enable  out  1  register file write
- ram_read_enable  out  1  data memory read request
- ram_write_enable  out  1  data memory write request
- write_back_select  out  1  0 = ALU result, 1 = RAM data
- halted  out  1  illegal instruction seen; sticky until reset

## Operation
- States: FETCH, DECODE, EXECUTE, MEM_READ, MEM_WRITE, WRITEBACK, BRANCH, HALT.
- FETCH: ifetch_req=1; when mem_ready=1, ir_write=1, pc_write=1, pc_src=0 -> DECODE; else hold.
- DECODE: classify opcode. 000000 R-type, 100011 lw, 101011 sw, 001000 addi -> EXECUTE; 000100 beq -> BRANCH; any other -> HALT.
- EXECUTE: R-type: alu_ctrl from funct, alu_src=0 -> WRITEBACK. lw/sw/addi: alu_ctrl=ADD, alu_src=1; lw -> MEM_READ, sw -> MEM_WRITE, addi -> WRITEBACK.
- MEM_READ: alu_ctrl=ADD, alu_src=1, ram_read_enable=1; on mem_ready -> WRITEBACK, else hold.
- MEM_WRITE: alu_ctrl=ADD, alu_src=1, ram_write_enable=1; on mem_ready -> FETCH, else hold.
- WRITEBACK: reg_write_enable=1; R-type: reg_dest=1, write_back_select=0; addi: reg_dest=0, write_back_select=0; lw: reg_dest=0, write_back_select=1, alu_ctrl=ADD, alu_src=1 held -> FETCH.
- BRANCH: alu_ctrl=SUB, alu_src=0, pc_src=1, pc_write=zero -> FETCH.
- HALT: all enables 0, halted=1; stays until reset.
- Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct in R-type DECODE -> HALT.
- alu_ctrl encodings: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Outputs not listed for a state are 0.

## Timing
- Reset: while reset=1, all outputs 0 and halted=0. Next state is FETCH at the edge. mem_ready is ignored while reset=1. Reset aborts any state, including mid-stall and HALT.
- Latency with mem_ready=1 every cycle: beq 3 cycles; R-type, addi, sw 4; lw 5. Each cycle mem_ready=0 in FETCH/MEM_READ/MEM_WRITE adds one cycle.
- ir_write, pc_write in FETCH and pc_write in BRANCH are combinational on mem_ready/zero. All other outputs decode from state and the held opcode/funct only.
- opcode/funct must stay stable from DECODE until return to FETCH (guaranteed: ir_write only in FETCH).
- No write enable is ever asserted in the same cycle as ir_write.

## Structure
- Shared package `smips_pkg`: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI), funct constants, alu_ctrl encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT).
- One sub-module: `alu_decoder` (funct -> alu_ctrl plus funct_valid), combinational.
- Single state register; next-state and output logic in separate combinational processes.

## Test plan
- Reset then add (opcode 000000, funct 100000), mem_ready=1 -> FETCH, DECODE, EXECUTE (alu_ctrl=010, alu_src=0), WRITEBACK (reg_write_enable=1, reg_dest=1), back in FETCH on cycle 5.
- lw (100011) with mem_ready low 2 cycles in MEM_READ -> ram_read_enable high 3 cycles; WRITEBACK has write_back_select=1, reg_dest=0; 7 cycles total.
- beq (000100) with zero=1 -> pc_write=1, pc_src=1 in BRANCH. With zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- sw (101011) -> ram_write_enable=1 in MEM_WRITE only, reg_write_enable never asserted.
- opcode 111111, or R-type funct 000000 -> HALT, halted=1 held 10+ cycles with all enables 0. Reset -> halted=0, FETCH.
- reset asserted in MEM_WRITE while mem_ready=0 -> ram_write_enable=0 that cycle, FETCH next cycle, no register or RAM write.
